// File: rtl/srv1_core.sv
// SRV1 RV32I multi-cycle core (FETCH/EXEC/LOAD), Harvard ports.
// Optional build macro SRV1_RV32E_EN: 16-entry register file, index bit 4 ignored.
module srv1_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clk_en,
  input  logic        sync_rst,
  output logic [29:0] inst_address,
  input  logic [31:0] inst_in,
  output logic [29:0] data_address,
  output logic [3:0]  data_mask,
  output logic [31:0] data_out,
  input  logic [31:0] data_in,
  output logic        memory_mode,
  output logic        bus_lock
);

`ifdef SRV1_RV32E_EN
  localparam int RF_AW = 4;
`else
  localparam int RF_AW = 5;
`endif
  localparam int RF_N = 1 << RF_AW;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_LOAD = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        rf_q [RF_N];
  logic [31:0]        ld_addr_q, ld_addr_d;
  logic [2:0]         ld_f3_q, ld_f3_d;
  logic [RF_AW-1:0]   ld_rd_q, ld_rd_d;
  logic               rf_we;
  logic [RF_AW-1:0]   rf_wa;
  logic [31:0]        rf_wd;

  logic [6:0]         opcode;
  logic [2:0]         f3;
  logic [RF_AW-1:0]   rd_idx, rs1_idx, rs2_idx;
  logic [31:0]        rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0]        alu_b, alu_res, eff_addr, pc_plus4, ld_shifted, ld_res;
  logic [4:0]         ld_shamt;
  logic               br_taken;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    lane_mask = 4'b0001 << a;
      2'd1:    lane_mask = a[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  assign opcode  = inst_in[6:0];
  assign f3      = inst_in[14:12];
  assign rd_idx  = inst_in[7 +: RF_AW];
  assign rs1_idx = inst_in[15 +: RF_AW];
  assign rs2_idx = inst_in[20 +: RF_AW];
  assign imm_i   = {{20{inst_in[31]}}, inst_in[31:20]};
  assign imm_s   = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
  assign imm_b   = {{19{inst_in[31]}}, inst_in[31], inst_in[7], inst_in[30:25], inst_in[11:8], 1'b0};
  assign imm_u   = {inst_in[31:12], 12'h000};
  assign imm_j   = {{11{inst_in[31]}}, inst_in[31], inst_in[19:12], inst_in[20], inst_in[30:21], 1'b0};
  assign rs1_v   = (rs1_idx == {RF_AW{1'b0}}) ? 32'h0 : rf_q[rs1_idx];
  assign rs2_v   = (rs2_idx == {RF_AW{1'b0}}) ? 32'h0 : rf_q[rs2_idx];
  assign pc_plus4     = pc_q + 32'd4;
  assign eff_addr     = rs1_v + ((opcode == OPC_STORE) ? imm_s : imm_i);
  assign alu_b        = (opcode == OPC_OP) ? rs2_v : imm_i;
  assign inst_address = pc_q[31:2];

  // ALU for OP and OP-IMM; bit 30 selects SUB (register form only) and SRA
  always_comb begin
    alu_res = 32'h0;
    case (f3)
      3'd0:    alu_res = ((opcode == OPC_OP) && inst_in[30]) ? rs1_v - alu_b : rs1_v + alu_b;
      3'd1:    alu_res = rs1_v << alu_b[4:0];
      3'd2:    alu_res = {31'h0, $signed(rs1_v) < $signed(alu_b)};
      3'd3:    alu_res = {31'h0, rs1_v < alu_b};
      3'd4:    alu_res = rs1_v ^ alu_b;
      3'd5:    alu_res = inst_in[30] ? $unsigned($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
      3'd6:    alu_res = rs1_v | alu_b;
      3'd7:    alu_res = rs1_v & alu_b;
      default: alu_res = 32'h0;
    endcase
  end

  // Branch condition evaluation
  always_comb begin
    br_taken = 1'b0;
    case (f3)
      3'd0:    br_taken = (rs1_v == rs2_v);
      3'd1:    br_taken = (rs1_v != rs2_v);
      3'd4:    br_taken = ($signed(rs1_v) < $signed(rs2_v));
      3'd5:    br_taken = ($signed(rs1_v) >= $signed(rs2_v));
      3'd6:    br_taken = (rs1_v < rs2_v);
      3'd7:    br_taken = (rs1_v >= rs2_v);
      default: br_taken = 1'b0;
    endcase
  end

  // Load data alignment: halfwords use only addr[1], words are never shifted
  always_comb begin
    ld_shamt = 5'd0;
    case (ld_f3_q[1:0])
      2'd0:    ld_shamt = {ld_addr_q[1:0], 3'b000};
      2'd1:    ld_shamt = {ld_addr_q[1], 4'b0000};
      default: ld_shamt = 5'd0;
    endcase
    ld_shifted = data_in >> ld_shamt;
    case (ld_f3_q)
      3'b000:  ld_res = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      3'b001:  ld_res = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      3'b100:  ld_res = {24'h0, ld_shifted[7:0]};
      3'b101:  ld_res = {16'h0, ld_shifted[15:0]};
      default: ld_res = ld_shifted;
    endcase
  end

  // Next-state, next-PC and register write-back
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ld_addr_d = ld_addr_q;
    ld_f3_d   = ld_f3_q;
    ld_rd_d   = ld_rd_q;
    rf_we     = 1'b0;
    rf_wa     = rd_idx;
    rf_wd     = 32'h0;
    case (state_q)
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_plus4;
        case (opcode)
          OPC_LUI:    begin rf_we = 1'b1; rf_wd = imm_u; end
          OPC_AUIPC:  begin rf_we = 1'b1; rf_wd = pc_q + imm_u; end
          OPC_JAL:    begin rf_we = 1'b1; rf_wd = pc_plus4; pc_d = pc_q + imm_j; end
          OPC_JALR:   begin rf_we = 1'b1; rf_wd = pc_plus4; pc_d = (rs1_v + imm_i) & ~32'h1; end
          OPC_BRANCH: pc_d = br_taken ? pc_q + imm_b : pc_plus4;
          OPC_OPIMM,
          OPC_OP:     begin rf_we = 1'b1; rf_wd = alu_res; end
          OPC_LOAD: begin
            state_d   = S_LOAD;
            pc_d      = pc_q;
            ld_addr_d = eff_addr;
            ld_f3_d   = f3;
            ld_rd_d   = rd_idx;
          end
          default:    pc_d = pc_plus4;
        endcase
      end
      S_LOAD: begin
        state_d = S_FETCH;
        pc_d    = pc_plus4;
        rf_we   = 1'b1;
        rf_wa   = ld_rd_q;
        rf_wd   = ld_res;
      end
      default: state_d = S_FETCH;
    endcase
    if (rf_wa == {RF_AW{1'b0}}) begin
      rf_we = 1'b0;
    end else begin
      rf_we = rf_we;
    end
  end

  // Data port drive: live decode in EXEC, captured access in LOAD
  always_comb begin
    data_address = 30'h0;
    data_mask    = 4'b0000;
    data_out     = 32'h0;
    memory_mode  = 1'b0;
    bus_lock     = 1'b0;
    if ((state_q == S_EXEC) && ((opcode == OPC_LOAD) || (opcode == OPC_STORE))) begin
      data_address = eff_addr[31:2];
      data_mask    = lane_mask(f3[1:0], eff_addr[1:0]);
      bus_lock     = 1'b1;
      if (opcode == OPC_STORE) begin
        memory_mode = 1'b1;
        case (f3[1:0])
          2'd0:    data_out = {4{rs2_v[7:0]}};
          2'd1:    data_out = {2{rs2_v[15:0]}};
          default: data_out = rs2_v;
        endcase
      end else begin
        memory_mode = 1'b0;
      end
    end else if (state_q == S_LOAD) begin
      data_address = ld_addr_q[31:2];
      data_mask    = lane_mask(ld_f3_q[1:0], ld_addr_q[1:0]);
      bus_lock     = 1'b1;
    end else begin
      bus_lock = 1'b0;
    end
  end

  // State register; PC kept word aligned so odd jump targets fetch truncated
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ld_addr_q <= 32'h0;
      ld_f3_q   <= 3'd0;
      ld_rd_q   <= {RF_AW{1'b0}};
      for (int i = 0; i < RF_N; i++) rf_q[i] <= 32'h0;
    end else if (clk_en) begin
      state_q   <= state_d;
      pc_q      <= {pc_d[31:2], 2'b00};
      ld_addr_q <= ld_addr_d;
      ld_f3_q   <= ld_f3_d;
      ld_rd_q   <= ld_rd_d;
      if (rf_we) rf_q[rf_wa] <= rf_wd;
    end
  end

endmodule

// File: tb/tb_srv1_core.sv
// Self-checking bench for srv1_core: program table with expected stores,
// store scoreboard, and hand sequences for reset, clk_en freeze and control flow.
module tb_srv1_core;
  logic        clk = 1'b0;
  logic        clk_en, sync_rst;
  logic [29:0] inst_address, data_address;
  logic [31:0] inst_in, data_out, data_in;
  logic [3:0]  data_mask;
  logic        memory_mode, bus_lock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] inst;
    bit          st;
    logic [29:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } vec_t;
  typedef struct {
    logic [29:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } exp_t;

  vec_t        prog [40];
  exp_t        sbq [$];
  logic [31:0] rom [64];
  logic [29:0] prev_ia;

  srv1_core #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .clk_en(clk_en), .sync_rst(sync_rst),
    .inst_address(inst_address), .inst_in(inst_in),
    .data_address(data_address), .data_mask(data_mask), .data_out(data_out),
    .data_in(data_in), .memory_mode(memory_mode), .bus_lock(bus_lock)
  );

  always #5 clk = ~clk;
  assign data_in = 32'h2001_0000;
  always @(posedge clk) inst_in <= rom[inst_address[5:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction
  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
    return {imm20[19:0], rd[4:0], op};
  endfunction
  function automatic vec_t mk(input logic [31:0] inst);
    return '{inst, 1'b0, 30'h0, 4'h0, 32'h0};
  endfunction
  function automatic vec_t mks(input logic [31:0] inst, input logic [29:0] a, input logic [3:0] m, input logic [31:0] d);
    return '{inst, 1'b1, a, m, d};
  endfunction

  // Store scoreboard: every write cycle must match the next expected store
  always @(negedge clk) begin
    if (memory_mode) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_store: addr %h data %h, none expected", data_address, data_out);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("store_addr", {2'b00, data_address}, {2'b00, e.addr});
        chk("store_mask", {28'h0, data_mask}, {28'h0, e.mask});
        chk("store_data", data_out, e.data);
        chk("store_lock", {31'h0, bus_lock}, 32'h1);
      end
    end
  end

  // Control-flow targets: fetch address after leaving a jump/branch word
  always @(negedge clk) begin
    if (!sync_rst && (prev_ia != inst_address)) begin
      case (prev_ia)
        30'd16:  chk("bne_target",  {2'b00, inst_address}, 32'd18);
        30'd18:  chk("jal_target",  {2'b00, inst_address}, 32'd20);
        30'd34:  chk("jalr_target", {2'b00, inst_address}, 32'd38);
        default: ;
      endcase
    end
    prev_ia <= inst_address;
  end

  initial begin
    sync_rst = 1'b1;
    clk_en   = 1'b1;
    prog[0]  = mk(enc_i(0, 0, 2, 1, 7'h03));                             // LW  x1,0
    prog[1]  = mk(enc_i(2, 0, 0, 2, 7'h03));                             // LB  x2,2
    prog[2]  = mk(enc_i(3, 0, 4, 4, 7'h03));                             // LBU x4,3
    prog[3]  = mk(enc_i(2, 0, 1, 3, 7'h03));                             // LH  x3,2
    prog[4]  = mks(enc_s(32'h40, 1, 0, 2), 30'h10, 4'hF, 32'h2001_0000);
    prog[5]  = mks(enc_s(32'h44, 2, 0, 2), 30'h11, 4'hF, 32'h0000_0001);
    prog[6]  = mks(enc_s(32'h48, 4, 0, 2), 30'h12, 4'hF, 32'h0000_0020);
    prog[7]  = mks(enc_s(32'h4C, 3, 0, 2), 30'h13, 4'hF, 32'h0000_2001);
    prog[8]  = mk(enc_i(32'h7F, 0, 0, 5, 7'h13));                         // ADDI x5,0x7F
    prog[9]  = mks(enc_s(3, 5, 0, 0), 30'h0, 4'b1000, 32'h7F7F_7F7F);     // SB x5,3
    prog[10] = mk(enc_i(-1, 0, 0, 6, 7'h13));                             // ADDI x6,-1
    prog[11] = mk(enc_i(32'h404, 6, 5, 7, 7'h13));                        // SRAI x7,x6,4
    prog[12] = mk(enc_i(4, 6, 5, 8, 7'h13));                              // SRLI x8,x6,4
    prog[13] = mks(enc_s(32'h50, 7, 0, 2), 30'h14, 4'hF, 32'hFFFF_FFFF);
    prog[14] = mks(enc_s(32'h54, 8, 0, 2), 30'h15, 4'hF, 32'h0FFF_FFFF);
    prog[15] = mks(enc_s(6, 6, 0, 1), 30'h1, 4'b1100, 32'hFFFF_FFFF);     // SH x6,6
    prog[16] = mk(enc_b(8, 6, 0, 1));                                     // BNE x0,x6,+8
    prog[17] = mk(enc_s(32'h58, 6, 0, 2));                                // skipped
    prog[18] = mk(enc_j(8, 1));                                           // JAL x1,+8
    prog[19] = mk(enc_s(32'h5C, 6, 0, 2));                                // skipped
    prog[20] = mks(enc_s(32'h60, 1, 0, 2), 30'h18, 4'hF, 32'h0000_004C);
    prog[21] = mk(enc_u(32'h12345, 9, 7'h37));                            // LUI x9
    prog[22] = mk(enc_u(1, 10, 7'h17));                                   // AUIPC x10 @0x58
    prog[23] = mk(enc_r(0, 10, 9, 0, 11));                                // ADD x11
    prog[24] = mk(enc_r(32'h20, 5, 0, 0, 12));                            // SUB x12
    prog[25] = mk(enc_r(0, 5, 6, 2, 13));                                 // SLT x13
    prog[26] = mk(enc_r(0, 6, 5, 3, 14));                                 // SLTU x14
    prog[27] = mk(enc_r(0, 13, 5, 1, 15));                                // SLL x15
    prog[28] = mks(enc_s(32'h64, 11, 0, 2), 30'h19, 4'hF, 32'h1234_6058);
    prog[29] = mks(enc_s(32'h68, 12, 0, 2), 30'h1A, 4'hF, 32'hFFFF_FF81);
    prog[30] = mks(enc_s(32'h6C, 15, 0, 2), 30'h1B, 4'hF, 32'h0000_00FE);
    prog[31] = mks(enc_s(32'h70, 14, 0, 2), 30'h1C, 4'hF, 32'h0000_0001);
    prog[32] = mk(enc_i(5, 0, 0, 0, 7'h13));                              // ADDI x0,5
    prog[33] = mks(enc_s(32'h74, 0, 0, 2), 30'h1D, 4'hF, 32'h0000_0000);
    prog[34] = mk(enc_i(32'h9B, 0, 0, 2, 7'h67));                         // JALR x2,0x9B
    for (int i = 35; i < 38; i++) prog[i] = mk(enc_s(32'h78, 6, 0, 2));  // skipped
    prog[38] = mks(enc_s(32'h7C, 2, 0, 2), 30'h1F, 4'hF, 32'h0000_008C);
    prog[39] = mk(enc_b(0, 0, 0, 0));                                     // BEQ self loop
    for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0013;
    for (int i = 0; i < 40; i++) begin
      rom[i] = prog[i].inst;
      if (prog[i].st) sbq.push_back('{prog[i].addr, prog[i].mask, prog[i].data});
    end

    repeat (3) @(negedge clk);
    chk("rst_inst_addr", {2'b00, inst_address}, 32'h0);
    chk("rst_data_addr", {2'b00, data_address}, 32'h0);
    chk("rst_mask", {28'h0, data_mask}, 32'h0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_mode_lock", {30'h0, memory_mode, bus_lock}, 32'h0);
    sync_rst = 1'b0;

    @(negedge clk);  // EXEC of LW x1,0
    chk("lw_exec_lock", {31'h0, bus_lock}, 32'h1);
    chk("lw_exec_mask", {28'h0, data_mask}, 32'hF);
    chk("lw_exec_mode", {31'h0, memory_mode}, 32'h0);
    @(negedge clk);  // LOAD: freeze five cycles
    clk_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("frz_lock", {31'h0, bus_lock}, 32'h1);
    chk("frz_mask", {28'h0, data_mask}, 32'hF);
    chk("frz_data_addr", {2'b00, data_address}, 32'h0);
    chk("frz_inst_addr", {2'b00, inst_address}, 32'h0);
    clk_en = 1'b1;
    @(negedge clk);  // second FETCH
    chk("fetch2_inst_addr", {2'b00, inst_address}, 32'h1);
    chk("fetch2_lock_mask", {27'h0, bus_lock, data_mask}, 32'h0);

    for (int i = 0; i < 600 && sbq.size() != 0; i++) @(negedge clk);
    chk("stores_remaining", sbq.size(), 32'd0);
    repeat (10) @(negedge clk);
    chk("loop_inst_addr", {2'b00, inst_address}, 32'd39);

    sync_rst = 1'b1;
    @(negedge clk);
    chk("srst_inst_addr", {2'b00, inst_address}, 32'h0);
    chk("srst_lock_mask", {27'h0, bus_lock, data_mask}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
